pulp_sync_multi: RTL and testbench
==================================

# pulp_sync_multi

Multi-channel clock-domain-crossing synchronizer for quasi-static level signals (pads, interrupts, handshake levels from other clock domains). Each of WIDTH channels runs through an independent STAGES-deep flop chain into a registered output level, with rising/falling edge pulses for interrupt and event logic. An optional compile-time glitch filter requires a new level to be stable for FILTER_CYCLES consecutive cycles before it propagates. Channels are independent: no multi-bit coherency is provided, and buses must use a handshake or gray-coded CDC instead.

## Interface
- WIDTH, 1 — number of independent channels, ≥1.
- STAGES, 2 — synchronizer depth per channel, legal range 2..4.
- RESET_VALUE, '0 — WIDTH-bit value loaded into every flop of channel i (bit i) on reset.
- FILTER_CYCLES, 4 — required stable cycles, legal range 1..255; used only when the filter is compiled in.
- clk_i  in  1  destination clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- serial_i  in  WIDTH  asynchronous inputs.
- serial_o  out  WIDTH  synchronized (filtered) level.
- r_edge_o  out  WIDTH  one-cycle pulse, asserted in the first cycle serial_o[i] reads 1 after having been 0.
- f_edge_o  out  WIDTH  one-cycle pulse, asserted in the first cycle serial_o[i] reads 0 after having been 1.

## Operation
- Per channel: chain sync_q[0..STAGES-1]; sync_q[0] <= serial_i, sync_q[n] <= sync_q[n-1]; s = sync_q[STAGES-1].
- Level register lvl_q drives serial_o; delayed copy lvl_d_q <= lvl_q every cycle.
- r_edge_o = lvl_q & ~lvl_d_q; f_edge_o = ~lvl_q & lvl_d_q. Both are combinational from flops only, glitch-free, and mutually exclusive.
- No filter: lvl_q <= s every cycle.
- Filter: per-channel counter cnt_q, width $clog2(FILTER_CYCLES+1).
  - s == lvl_q: cnt_q <= 0.
  - s != lvl_q and cnt_q == FILTER_CYCLES-1: lvl_q <= s, cnt_q <= 0.
  - s != lvl_q otherwise: cnt_q <= cnt_q+1.
  - A pulse on s shorter than FILTER_CYCLES cycles is discarded. The counter restarts from 0 on every return to the current level, including a bounce mid-count.
- Reset (async, any time, including mid-count): all sync_q, lvl_q and lvl_d_q bits take RESET_VALUE[i]; cnt_q = 0. serial_o = RESET_VALUE, edges = 0 during and after reset. No spurious edge on release.
- Simulation only (excluded under SYNTHESIS): $fatal at time 0 if STAGES is outside 2..4 or FILTER_CYCLES is outside 1..255.

## Timing
- Input change captured at rising edge k: without the filter, serial_o and the edge pulse change after edge k+STAGES (latency STAGES+1 edges).
- With the filter: serial_o changes after edge k+STAGES-1+FILTER_CYCLES. FILTER_CYCLES=1 is cycle-identical to no filter.
- Each edge pulse is exactly 1 cycle wide. Without the filter, a level held for ≥1 capture cycle yields one pulse per transition. Toggling faster than the clock may alias; no transition counting is guaranteed.
- The first stage is a metastability-capture flop. No combinational path from serial_i to any output.

## Configuration
- PULP_SYNC_FILTER_EN defined: glitch filter and counters present, FILTER_CYCLES active.
- Not defined: no counters, lvl_q <= s, FILTER_CYCLES ignored (parameter still declared).

## Test plan
- Reset: WIDTH=4, RESET_VALUE=4'b1010, serial_i=4'b1010 held. Assert and release rstn_i. Expect serial_o=4'b1010, r_edge_o=f_edge_o=0 on every cycle after release.
- Latency: no filter, STAGES=3. Raise serial_i[0] before edge k. Expect serial_o[0]=1 and r_edge_o[0]=1 after edge k+3, r_edge_o[0]=0 after edge k+4. Drop it and expect the same for f_edge_o[0].
- Filter reject: filter on, STAGES=2, FILTER_CYCLES=4. A 3-cycle high pulse gives serial_o=0 with no edges. A 4-cycle pulse gives serial_o high after edge k+5, followed by a f_edge_o pulse.
- Bounce mid-count: filter on, FILTER_CYCLES=4. Input pattern 1,1,1,0,1,1,1,1 (one value per cycle). Expect the counter to restart and serial_o to rise only after the final 4-cycle run.
- Async reset mid-count: filter on, cnt_q=2, serial_o=1. Pulse rstn_i low between clock edges. Expect immediate serial_o=RESET_VALUE, cnt_q=0, and no edge pulse on release.
- Channel independence: WIDTH=8, random per-bit toggles with holds of ≥FILTER_CYCLES+STAGES cycles. A scoreboard checks per-bit latency and exactly one edge pulse per transition.

Source files
------------

// File: rtl/pulp_sync_multi.sv
// pulp_sync_multi: independent per-channel flop-chain level synchronizers with edge pulses.
// Define PULP_SYNC_FILTER_EN to add a per-channel glitch filter (FILTER_CYCLES stable cycles).
module pulp_sync_multi #(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int unsigned      FILTER_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] serial_i,
    output logic [WIDTH-1:0] serial_o,
    output logic [WIDTH-1:0] r_edge_o,
    output logic [WIDTH-1:0] f_edge_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sync_s;
    logic [WIDTH-1:0]             lvl_d;
    logic [WIDTH-1:0]             lvl_q;
    logic [WIDTH-1:0]             lvl_d_q;

`ifndef SYNTHESIS
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "pulp_sync_multi: STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $fatal(1, "pulp_sync_multi: FILTER_CYCLES must be in 1..255");
    end
`endif

    // Stage 0 is the metastability-capture flop; higher indices are older samples.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], serial_i};
        end
    end

    assign sync_s = sync_q[STAGES-1];

`ifdef PULP_SYNC_FILTER_EN
    localparam int unsigned      CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // Any return to the current level, even for one cycle, restarts the count.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_s[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign lvl_d = sync_s;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lvl_q   <= RESET_VALUE;
            lvl_d_q <= RESET_VALUE;
        end else begin
            lvl_q   <= lvl_d;
            lvl_d_q <= lvl_q;
        end
    end

    // Edges derive from two flops only, so they cannot glitch and never overlap.
    assign serial_o = lvl_q;
    assign r_edge_o = lvl_q & ~lvl_d_q;
    assign f_edge_o = ~lvl_q & lvl_d_q;

endmodule

// File: tb/tb_pulp_sync_multi.sv
// tb_pulp_sync_multi: randomized self-checking bench for pulp_sync_multi against a
// history-window reference model; follows PULP_SYNC_FILTER_EN like the design does.
module tb_pulp_sync_multi;

    localparam int unsigned W  = 8;
    localparam int unsigned ST = 3;
    localparam logic [W-1:0] RV = 8'hA5;
    localparam int unsigned FC = 4;
`ifdef PULP_SYNC_FILTER_EN
    localparam int unsigned MF = FC;
`else
    localparam int unsigned MF = 1;
`endif

    logic         clk_i;
    logic         rstn_i;
    logic [W-1:0] serial_i;
    logic [W-1:0] serial_o;
    logic [W-1:0] r_edge_o;
    logic [W-1:0] f_edge_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] m_lvl;
    logic [W-1:0] m_prev;

    pulp_sync_multi #(
        .WIDTH(W),
        .STAGES(ST),
        .RESET_VALUE(RV),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .serial_i(serial_i),
        .serial_o(serial_o),
        .r_edge_o(r_edge_o),
        .f_edge_o(f_edge_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Before the first post-reset capture the chain holds RESET_VALUE.
    function automatic void modelReset();
        hist.delete();
        for (int i = 0; i < int'(ST + MF + 2); i++) hist.push_back(RV);
        m_lvl  = RV;
        m_prev = RV;
    endfunction

    // A bit changes once the last MF synchronized samples all disagree with it;
    // the sample reaching the level logic at this edge was captured ST edges ago.
    function automatic void modelStep(input logic [W-1:0] in);
        logic all_new;
        hist.push_back(in);
        if (hist.size() > 64) void'(hist.pop_front());
        m_prev = m_lvl;
        for (int b = 0; b < int'(W); b++) begin
            all_new = 1'b1;
            for (int j = 0; j < int'(MF); j++) begin
                if (hist[hist.size() - 1 - ST - j][b] == m_lvl[b]) all_new = 1'b0;
            end
            if (all_new) m_lvl[b] = ~m_lvl[b];
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".level"}, serial_o, m_lvl);
        checkOutput({tag, ".rise"}, r_edge_o, m_lvl & ~m_prev);
        checkOutput({tag, ".fall"}, f_edge_o, ~m_lvl & m_prev);
    endtask

    task automatic applyStimulus(input logic [W-1:0] value, input int cycles, input string tag);
        serial_i = value;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i);
            if (rstn_i) modelStep(serial_i);
            @(negedge clk_i);
            checkAll(tag);
        end
    endtask

    initial begin
        logic [W-1:0] val;
        int           hold[W];

        rstn_i   = 1'b1;
        serial_i = RV;
        modelReset();
        #1 rstn_i = 1'b0;
        #2 checkAll("in_reset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        applyStimulus(RV, 6, "post_reset");

        // Single-channel latency on bit 0, rising then falling.
        applyStimulus(RV ^ 8'h01, 10, "lat_rise");
        applyStimulus(RV, 10, "lat_fall");

        // Short and just-long-enough pulses on bit 1.
        applyStimulus(RV ^ 8'h02, 3, "pulse3");
        applyStimulus(RV, 10, "pulse3_idle");
        applyStimulus(RV ^ 8'h02, 4, "pulse4");
        applyStimulus(RV, 12, "pulse4_idle");

        // Bounce mid-count on bit 2: away x3, back x1, away held.
        applyStimulus(RV ^ 8'h04, 3, "bounce_a");
        applyStimulus(RV, 1, "bounce_b");
        applyStimulus(RV ^ 8'h04, 12, "bounce_c");
        applyStimulus(RV, 12, "bounce_d");

        // Independent random holds per bit, short ones included to exercise rejection.
        val = RV;
        for (int b = 0; b < int'(W); b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 300; c++) begin
            for (int b = 0; b < int'(W); b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    val[b]  = ~val[b];
                    hold[b] = (($urandom & 3) == 0) ? $urandom_range(1, 3)
                                                    : $urandom_range(ST + MF, 14);
                end
            end
            applyStimulus(val, 1, "random");
        end
        applyStimulus(RV, 12, "settle");

        // Asynchronous reset in the middle of a filter count.
        applyStimulus(~RV, 5, "pre_areset");
        #2 rstn_i = 1'b0;
        modelReset();
        #1 checkAll("areset_now");
        @(posedge clk_i);
        @(negedge clk_i);
        checkAll("areset_hold");
        rstn_i = 1'b1;
        applyStimulus(~RV, 12, "after_areset");
        applyStimulus(RV, 12, "after_areset_back");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
